// File: rtl/int_fp_acc.sv
// int_fp_acc: sums groups of int16 or FP16 products; fp uses an exact fixed-point register.
// Define ACC_RNE_EN for round-to-nearest-even FP16 conversion; default truncates.
module int_fp_acc #(
    parameter int ACC_W   = 52,
    parameter int MAX_LEN = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mode,
    input  logic [15:0] in_prod,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_ovf
);
    localparam int CW = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {ACC, SAT, CV1, CV2, OUT} state_t;

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] mag_q;
    logic [CW-1:0]    cnt_q;
    logic             mode_q;
    logic             spec_q;
    logic             sign_q;
    logic             out_valid_q;
    logic             out_ovf_q;
    logic [31:0]      out_data_q;

    logic             beat;
    logic             mode_d;
    logic             close;
    logic             spec_hit;
    logic             fits;
    logic [ACC_W-1:0] addend_d;
    logic [ACC_W-1:0] fmag;
    logic [ACC_W-1:0] norm;
    logic [10:0]      mr;
    logic [15:0]      fp_d;
    logic             fovf_d;
    int               p;
    int               e;

    assign in_ready  = (state_q == ACC);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    assign beat   = in_valid && in_ready;
    assign mode_d = (cnt_q == '0) ? in_mode : mode_q;
    assign close  = in_last || (cnt_q == CW'(MAX_LEN - 1));
    assign fits   = (&acc_q[ACC_W-1:31]) | ~(|acc_q[ACC_W-1:31]);

    // FP16 beats land at a fixed binary point: LSB weight 2^-24.
    always_comb begin
        addend_d = '0;
        spec_hit = 1'b0;
        fmag = {{(ACC_W-11){1'b0}}, 1'b1, in_prod[9:0]}
               << (in_prod[14:10] - 5'd1);
        if (!mode_d) begin
            addend_d = {{(ACC_W-16){in_prod[15]}}, in_prod};
        end else if (in_prod[14:10] == 5'd31) begin
            spec_hit = 1'b1;
        end else if (in_prod[14:10] != 5'd0) begin
            addend_d = in_prod[15] ? -fmag : fmag;
        end
    end

    always_comb begin
        p = 0;
        for (int i = 0; i < ACC_W; i++) begin
            if (mag_q[i]) p = i;
        end
        norm = mag_q << (ACC_W - 1 - p);
        e = p - 9;
        mr = {1'b0, norm[ACC_W-2 -: 10]};
`ifdef ACC_RNE_EN
        if (norm[ACC_W-12] &&
            (norm[ACC_W-11] || (|norm[ACC_W-13:0]))) begin
            mr = mr + 11'd1;
        end
        if (mr[10]) e = e + 1;
`endif
        fp_d = 16'h0000;
        fovf_d = 1'b0;
        if (spec_q) begin
            fp_d = 16'h7E00;
            fovf_d = 1'b1;
        end else if (mag_q == '0 || e < 1) begin
            fp_d = 16'h0000;
        end else if (e >= 31) begin
            fp_d = {sign_q, 15'h7C00};
            fovf_d = 1'b1;
        end else begin
            fp_d = {sign_q, e[4:0], mr[9:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACC;
            acc_q       <= '0;
            mag_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            spec_q      <= 1'b0;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            unique case (state_q)
                ACC: begin
                    if (beat) begin
                        acc_q  <= acc_q + addend_d;
                        spec_q <= spec_q | spec_hit;
                        mode_q <= mode_d;
                        if (close) begin
                            cnt_q   <= '0;
                            state_q <= mode_d ? CV1 : SAT;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                SAT: begin
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                    if (fits) begin
                        out_data_q <= acc_q[31:0];
                        out_ovf_q  <= 1'b0;
                    end else begin
                        out_data_q <= acc_q[ACC_W-1] ? 32'h8000_0000
                                                     : 32'h7FFF_FFFF;
                        out_ovf_q  <= 1'b1;
                    end
                end
                CV1: begin
                    sign_q  <= acc_q[ACC_W-1];
                    mag_q   <= acc_q[ACC_W-1] ? -acc_q : acc_q;
                    state_q <= CV2;
                end
                CV2: begin
                    out_data_q  <= {16'h0000, fp_d};
                    out_ovf_q   <= fovf_d;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        spec_q      <= 1'b0;
                        state_q     <= ACC;
                    end
                end
                default: state_q <= ACC;
            endcase
        end
    end
endmodule
